spi_master: RTL and testbench

// - SPI master, mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first, full duplex.
// - Sits between internal logic and an external SPI slave (controller/peripheral).
// - Internal chip-select request CS_n_i plus rdy starts byte transfers.
// - Bytes repeat back-to-back while the request is held; each received byte is

---
 rtl/spi_master.sv | 135 +++++++++++++
 tb/tb_spi_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// spi_master: SPI mode-0 (CPOL=0, CPHA=0) byte master, MSB first, with back-to-back streaming.
// Rev 1.0

module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] MOSI_data,
  input  logic       CS_n_i,
  input  logic       rdy,
  output logic [7:0] MISO_data,
  output logic       done,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCK,
  output logic       CS_n
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    nrise;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;

  wire last  = (cnt == CW'(CLK_DIV - 1));
  wire start = !CS_n_i && rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nrise     <= 4'd0;
      tx_sr     <= 8'h00;
      rx_sr     <= 8'h00;
      MISO_data <= 8'h00;
      done      <= 1'b0;
      MOSI      <= 1'b0;
      SCK       <= 1'b0;
      CS_n      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            tx_sr <= MOSI_data;
            MOSI  <= MOSI_data[7];
            CS_n  <= 1'b0;
            nrise <= 4'd0;
            state <= LEAD;
          end
        end

        // Setup time between CS_n assertion and the first rising edge.
        LEAD: begin
          if (last) begin
            cnt   <= '0;
            SCK   <= 1'b1;
            rx_sr <= {rx_sr[6:0], MISO};
            nrise <= 4'd1;
            state <= SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        SHIFT: begin
          if (!last) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt <= '0;
            if (!SCK) begin
              SCK   <= 1'b1;
              rx_sr <= {rx_sr[6:0], MISO};
              nrise <= nrise + 4'd1;
            end else begin
              SCK <= 1'b0;
              // The 8th fall closes the byte; request inputs are only looked at here.
              if (nrise == 4'd8) begin
                MISO_data <= rx_sr;
                done      <= 1'b1;
                nrise     <= 4'd0;
                if (start) begin
                  tx_sr <= MOSI_data;
                  MOSI  <= MOSI_data[7];
                end else begin
                  state <= TRAIL;
                end
              end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
                MOSI  <= tx_sr[6];
              end
            end
          end
        end

        TRAIL: begin
          if (last) begin
            cnt   <= '0;
            CS_n  <= 1'b1;
            state <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        GAP: begin
          if (last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// tb_spi_master: randomized bench with a queue-based SPI slave model for spi_master.
// Rev 1.0

module tb_spi_master;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] MOSI_data;
  logic       CS_n_i;
  logic       rdy;
  logic [7:0] MISO_data;
  logic       done;
  logic       MISO = 1'b0;
  logic       MOSI;
  logic       SCK;
  logic       CS_n;

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .MOSI_data(MOSI_data), .CS_n_i(CS_n_i), .rdy(rdy),
    .MISO_data(MISO_data), .done(done), .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .CS_n(CS_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Slave model and observation state, all updated away from the active edge.
  logic [7:0] miso_q[$];
  logic [7:0] got_q[$];
  logic [7:0] slave_q[$];
  int         done_cyc_q[$];
  logic       prev_sck = 1'b0;
  logic       prev_cs  = 1'b1;
  logic [7:0] stx = 8'h00;
  logic [7:0] srx = 8'h00;
  int sbit = 0, rise_cnt = 0, cs_rise_cnt = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
  int last_rise = 0, last_fall = 0, hp_err = 0, done_cnt = 0, last_done_cyc = 0;

  always @(negedge clk) begin
    if (prev_cs === 1'b1 && CS_n === 1'b0) begin
      cs_fall_cyc = cyc;
      sbit = 0;
      stx = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
      MISO = stx[7];
    end
    if (prev_cs === 1'b0 && CS_n === 1'b1) begin
      cs_rise_cnt++;
      cs_rise_cyc = cyc;
    end
    if (prev_sck === 1'b0 && SCK === 1'b1) begin
      rise_cnt++;
      srx = {srx[6:0], MOSI};
      sbit++;
      if (last_fall > cs_fall_cyc) begin
        if (cyc - last_fall != D) hp_err++;
      end else if (cyc - cs_fall_cyc != D) begin
        hp_err++;
      end
      last_rise = cyc;
      if (sbit == 8) begin
        slave_q.push_back(srx);
        sbit = 0;
      end
    end
    if (prev_sck === 1'b1 && SCK === 1'b0) begin
      if (cyc - last_rise != D) hp_err++;
      last_fall = cyc;
      if (sbit == 0) begin
        stx = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
        MISO = stx[7];
      end else begin
        MISO = stx[7-sbit];
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      got_q.push_back(MISO_data);
      done_cyc_q.push_back(cyc);
      last_done_cyc = cyc;
    end
    prev_sck = SCK;
    prev_cs  = CS_n;
  end

  logic [7:0] tx_a[4];
  logic [7:0] rx_a[4];

  // One transaction of n bytes: tx_a goes out, rx_a is what the slave returns.
  task automatic xfer(input int n);
    int d0, r0, c0, h0, t0, prev, d;
    logic [7:0] b;
    for (int k = 0; k < n; k++) miso_q.push_back(rx_a[k]);
    d0 = done_cnt; r0 = rise_cnt; c0 = cs_rise_cnt; h0 = hp_err;
    MOSI_data = tx_a[0];
    CS_n_i = 1'b0;
    rdy = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20 && CS_n !== 1'b0; i++) tick;
    check("cs_assert_lat", cs_fall_cyc, t0 + 1);
    for (int k = 0; k < n; k++) begin
      repeat (2*D) tick;
      MOSI_data = 8'($urandom);
      repeat (4*D) tick;
      if (k < n - 1) MOSI_data = tx_a[k+1];
      else CS_n_i = 1'b1;
      for (int i = 0; i < 20*D && done_cnt < d0 + k + 1; i++) tick;
      check("done_seen", done_cnt, d0 + k + 1);
    end
    for (int i = 0; i < 4*D && CS_n !== 1'b1; i++) tick;
    check("cs_trail", cs_rise_cyc, last_done_cyc + D);
    check("sck_pulses", rise_cnt - r0, 8*n);
    check("cs_rises", cs_rise_cnt - c0, 1);
    check("half_period", hp_err - h0, 0);
    check("sck_idle", SCK, 1'b0);
    prev = cs_fall_cyc;
    for (int k = 0; k < n; k++) begin
      b = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      check("miso_data", b, rx_a[k]);
      b = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hxx;
      check("slave_rx", b, tx_a[k]);
      d = (done_cyc_q.size() > 0) ? done_cyc_q.pop_front() : -1;
      check("byte_period", d - prev, 16*D);
      prev = d;
    end
    repeat (2*D) tick;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst = 1'b1; CS_n_i = 1'b1; rdy = 1'b1; MOSI_data = 8'h00;
    repeat (3) tick;
    check("rst_sck", SCK, 1'b0);
    check("rst_cs", CS_n, 1'b1);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_miso_data", MISO_data, 8'h00);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    tick;

    tx_a[0] = 8'hCD; rx_a[0] = 8'h63;
    xfer(1);

    tx_a[0] = 8'h4D; tx_a[1] = 8'hA5; rx_a[0] = 8'($urandom); rx_a[1] = 8'($urandom);
    xfer(2);

    // Request held with rdy low must not start anything.
    rdy = 1'b0; CS_n_i = 1'b0; r0 = rise_cnt;
    repeat (5*D) tick;
    check("rdy_low_cs", CS_n, 1'b1);
    check("rdy_low_sck", rise_cnt - r0, 0);
    tx_a[0] = 8'($urandom); rx_a[0] = 8'($urandom);
    xfer(1);

    tx_a[0] = 8'($urandom); rx_a[0] = 8'hFF;
    xfer(1);
    tx_a[0] = 8'($urandom); rx_a[0] = 8'h00;
    xfer(1);

    for (int it = 0; it < 12; it++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < 4; k++) begin
        tx_a[k] = 8'($urandom);
        rx_a[k] = 8'($urandom);
      end
      rx_a[0][0] = 1'b1;
      xfer(n);
    end

    // Abort mid-byte with reset: MISO_data is non-zero beforehand.
    miso_q.push_back(8'h5A);
    MOSI_data = 8'h3C; CS_n_i = 1'b0; rdy = 1'b1; r0 = rise_cnt;
    for (int i = 0; i < 20*D && rise_cnt < r0 + 3; i++) tick;
    check("pre_abort_rises", rise_cnt - r0, 3);
    CS_n_i = 1'b1;
    rst = 1'b1;
    tick;
    check("abort_sck", SCK, 1'b0);
    check("abort_cs", CS_n, 1'b1);
    check("abort_miso_data", MISO_data, 8'h00);
    check("abort_done", done, 1'b0);
    tick;
    rst = 1'b0;
    r0 = rise_cnt;
    repeat (4*D) tick;
    check("post_abort_quiet", rise_cnt - r0, 0);
    check("post_abort_nodone", got_q.size(), 0);

    tx_a[0] = 8'h96; rx_a[0] = 8'h69;
    xfer(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
